counter_pc_seq: RTL and testbench
=================================

COUNTER_PC_SEQ -- requirements
Module: counter_pc_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter PC_WIDTH SHALL default to 16 and set the width of pc, pc_start and pc_stop.
REQ-003 Parameter STEP_WIDTH SHALL default to 4 and set the width of pc_step.
REQ-004 Parameter LOOP_WIDTH SHALL default to 8 and set the width of loop_cnt.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  launch request, sampled only in IDLE.
REQ-008 pause  input  1  freeze counting while high in RUN.
REQ-009 pc_start  input  PC_WIDTH  first PC of a pass, latched at launch.
REQ-010 pc_stop  input  PC_WIDTH  terminal PC, latched at launch.
REQ-011 pc_step  input  STEP_WIDTH  increment per cycle, latched at launch; 0 treated as 1.
REQ-012 loop_cnt  input  LOOP_WIDTH  extra passes after the first, latched at launch.
REQ-013 pc  output  PC_WIDTH  current PC.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 overflow  output  1  high with done when the run ended on PC carry-out.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE with start=1: latch all configuration, pc<=pc_start, loops<=loop_cnt, go to RUN; busy=1 from the next cycle.
REQ-019 start SHALL be ignored in RUN and DONE; inputs other than start/pause SHALL have no effect after launch.
REQ-020 RUN with pause=1: pc, loops and state SHALL hold; no stop or overflow check that cycle.
REQ-021 RUN, pause=0, pc >= stop (unsigned): if loops != 0 then pc<=start, loops<=loops-1; else go to DONE, pc holds.
REQ-022 RUN, pause=0, pc < stop: if pc+step carries out of PC_WIDTH bits, go to DONE with overflow set, pc holds; else pc<=pc+step.
REQ-023 Stop check SHALL take priority over overflow check in the same cycle.
REQ-024 DONE SHALL last exactly one cycle with done=1, busy=0, then return to IDLE; overflow SHALL be valid only while done=1 and 0 otherwise.
REQ-025 pc SHALL retain its final value in IDLE until the next launch.
REQ-026 pc_start >= pc_stop SHALL complete after one RUN cycle per pass without incrementing.

Reset
REQ-027 On rst=0, asynchronously: state=IDLE, pc=0, loops=0, busy=0, done=0, overflow=0, latched configuration cleared.
REQ-028 Reset mid-RUN SHALL abort with no done pulse; first launch allowed on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro COUNTER_PC_LOOP_EN SHALL compile in the loop counter and loop_cnt behaviour of REQ-021.
REQ-030 Without COUNTER_PC_LOOP_EN, the loop_cnt port SHALL still exist but be ignored, the loop register SHALL be absent, and every run SHALL be a single pass.

Verification
REQ-031 Reset-held-low -> pc=0, busy=0, done=0, overflow=0; drop rst mid-run (pc=20) -> all outputs cleared at once, no done.
REQ-032 start=0->1 pulse, pc_start=0, pc_stop=511, step=1, loop_cnt=0 -> busy 1 cycle after start, pc reaches 511, done 1 cycle later for 1 cycle, overflow=0, pc stays 511.
REQ-033 pc_start=10, pc_stop=20, step=4 -> pc 10,14,18,22 then done with pc=22; step=0 -> increments by 1.
REQ-034 PC_WIDTH=8, pc_start=250, pc_stop=255, step=8 -> pc 250 then done with overflow=1, pc=250.
REQ-035 With COUNTER_PC_LOOP_EN, pc_start=0, pc_stop=3, step=1, loop_cnt=2 -> three passes 0..3, one done pulse; without macro -> one pass.
REQ-036 pause high 5 cycles at pc=7 -> pc holds 7 for 5 cycles; start asserted during RUN -> no relaunch, config unchanged.

Source files
------------

// File: rtl/counter_pc_seq.sv
// Programmable PC sequencer: counts pc_start..pc_stop by pc_step, optionally repeating passes.
// Optional multi-pass looping is compiled in with `define COUNTER_PC_LOOP_EN.
module counter_pc_seq #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned STEP_WIDTH = 4,
  parameter int unsigned LOOP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  input  logic [PC_WIDTH-1:0]   pc_start,
  input  logic [PC_WIDTH-1:0]   pc_stop,
  input  logic [STEP_WIDTH-1:0] pc_step,
  input  logic [LOOP_WIDTH-1:0] loop_cnt,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   start_q;
  logic [PC_WIDTH-1:0]   stop_q;
  logic [STEP_WIDTH-1:0] step_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;

  logic [PC_WIDTH:0] sum;
  logic              at_stop;
  logic              more_loops;
  logic              launch;
  logic              reload;

  // Extra MSB captures the carry-out used for overflow detection.
  assign sum     = {1'b0, pc_q} + (PC_WIDTH+1)'(step_q);
  assign at_stop = (pc_q >= stop_q);
  assign launch  = (state_q == StIdle) && start;
  assign reload  = (state_q == StRun) && !pause && at_stop && more_loops;

`ifdef COUNTER_PC_LOOP_EN
  logic [LOOP_WIDTH-1:0] loops_q;

  assign more_loops = (loops_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loops_q <= '0;
    end else if (launch) begin
      loops_q <= loop_cnt;
    end else if (reload) begin
      loops_q <= loops_q - 1'b1;
    end
  end
`else
  logic unused_loop_cnt;

  assign unused_loop_cnt = ^loop_cnt;
  assign more_loops      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (launch) begin
            start_q <= pc_start;
            stop_q  <= pc_stop;
            step_q  <= (pc_step == '0) ? STEP_WIDTH'(1) : pc_step;
            pc_q    <= pc_start;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!pause) begin
            if (at_stop) begin
              if (reload) begin
                pc_q <= start_q;
              end else begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (sum[PC_WIDTH]) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ovf_q   <= 1'b1;
            end else begin
              pc_q <= sum[PC_WIDTH-1:0];
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_counter_pc_seq.sv
// Self-checking bench for counter_pc_seq: directed and random runs against a trajectory model.
module tb_counter_pc_seq;

`ifdef COUNTER_PC_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start8, pause;
  logic [15:0] pc_start, pc_stop;
  logic [3:0]  pc_step;
  logic [7:0]  loop_cnt;
  logic [15:0] pc16;
  logic [7:0]  pc8;
  logic        busy16, done16, ovf16, busy8, done8, ovf8;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit exp_ovf;

  always #5 clk = ~clk;

  counter_pc_seq dut16 (
    .clk(clk), .rst(rst), .start(start16), .pause(pause),
    .pc_start(pc_start), .pc_stop(pc_stop), .pc_step(pc_step), .loop_cnt(loop_cnt),
    .pc(pc16), .busy(busy16), .done(done16), .overflow(ovf16)
  );

  counter_pc_seq #(.PC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .pause(pause),
    .pc_start(pc_start[7:0]), .pc_stop(pc_stop[7:0]), .pc_step(pc_step), .loop_cnt(loop_cnt),
    .pc(pc8), .busy(busy8), .done(done8), .overflow(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Whole-run trajectory: one pc value per busy cycle, passes concatenated.
  function automatic void build(input int w, input int s, input int e, input int st,
                                input int lc);
    int stp;
    int passes;
    int p;
    stp     = (st == 0) ? 1 : st;
    passes  = LoopEn ? lc + 1 : 1;
    exp_ovf = 1'b0;
    exp_q.delete();
    for (int k = 0; k < passes; k++) begin
      p = s;
      forever begin
        exp_q.push_back(p);
        if (p >= e) break;
        if (p + stp >= (1 << w)) begin
          exp_ovf = 1'b1;
          return;
        end
        p = p + stp;
      end
    end
  endfunction

  function automatic logic [31:0] o_pc(input bit w8);
    return w8 ? {24'd0, pc8} : {16'd0, pc16};
  endfunction

  function automatic logic [2:0] o_flags(input bit w8);
    return w8 ? {busy8, done8, ovf8} : {busy16, done16, ovf16};
  endfunction

  task automatic run(input bit w8, input int s, input int e, input int st, input int lc,
                     input int pidx, input int plen, input bit jam);
    int last;
    build(w8 ? 8 : 16, s, e, st, lc);
    last     = exp_q[exp_q.size()-1];
    pc_start = 16'(s);
    pc_stop  = 16'(e);
    pc_step  = 4'(st);
    loop_cnt = 8'(lc);
    pause    = 1'b0;
    if (w8) start8 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("run_pc", o_pc(w8), 32'(exp_q[i]));
      chk("run_flags", 32'(o_flags(w8)), 32'b100);
      if (i == pidx) begin
        pause = 1'b1;
        repeat (plen) begin
          @(negedge clk);
          chk("pause_pc", o_pc(w8), 32'(exp_q[i]));
          chk("pause_busy", 32'(o_flags(w8)), 32'b100);
        end
        pause = 1'b0;
      end
      if (jam) begin
        if (w8) start8 = 1'b1; else start16 = 1'b1;
        pc_start = 16'($urandom);
        pc_stop  = 16'($urandom);
        pc_step  = 4'($urandom);
        loop_cnt = 8'($urandom);
      end
      @(negedge clk);
    end
    start8  = 1'b0;
    start16 = 1'b0;
    chk("done_pc", o_pc(w8), 32'(last));
    chk("done_flags", 32'(o_flags(w8)), {29'd0, 2'b01, exp_ovf});
    @(negedge clk);
    chk("idle_pc", o_pc(w8), 32'(last));
    chk("idle_flags", 32'(o_flags(w8)), 32'b000);
  endtask

  initial begin
    int s, e;
    rst = 1'b0; start16 = 1'b0; start8 = 1'b0; pause = 1'b0;
    pc_start = '0; pc_stop = '0; pc_step = '0; loop_cnt = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", o_pc(0), 0);
    chk("rst_flags", 32'(o_flags(0)), 0);
    chk("rst_flags8", 32'(o_flags(1)), 0);
    rst = 1'b1;

    run(0, 0, 511, 1, 0, -1, 0, 0);
    run(0, 10, 20, 4, 0, -1, 0, 0);
    run(0, 10, 20, 0, 0, -1, 0, 0);
    run(1, 250, 255, 8, 0, -1, 0, 0);
    run(0, 0, 3, 1, 2, -1, 0, 0);
    run(0, 0, 30, 1, 1, 7, 5, 1);
    run(0, 50, 20, 3, 1, -1, 0, 0);
    run(0, 65530, 65535, 2, 0, -1, 0, 0);

    // Asynchronous reset in the middle of a run.
    pc_start = 16'd0; pc_stop = 16'd100; pc_step = 4'd1; loop_cnt = 8'd0;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_pc", o_pc(0), 20);
    rst = 1'b0;
    #1;
    chk("async_rst_pc", o_pc(0), 0);
    chk("async_rst_flags", 32'(o_flags(0)), 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(o_flags(0)), 0);
    end
    rst = 1'b1;
    run(0, 5, 9, 2, 0, -1, 0, 0);

    for (int n = 0; n < 16; n++) begin
      if (n % 4 == 3) begin
        s = 65400 + $urandom_range(0, 100);
        e = 65535 - $urandom_range(0, 20);
      end else begin
        s = $urandom_range(0, 400);
        e = $urandom_range(0, 400);
      end
      run(0, s, e, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 20),
          $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 4; n++) begin
      run(1, $urandom_range(150, 255), $urandom_range(0, 255), $urandom_range(0, 15),
          $urandom_range(0, 2), $urandom_range(0, 10), $urandom_range(1, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
